// File: rtl/alu_req_scheduler_pkg.sv
// Shared types and constants for the ALU request scheduler.
package alu_req_scheduler_pkg;

  localparam int DATA_WIDTH_D   = 8;
  localparam int OPCODE_WIDTH_D = 4;
  localparam int FLAGS_W        = 4;

  // Bit positions of the ALU flags inside the 4-bit flag vector.
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_P = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Successor of requester index i in a ring of n requesters.
  function automatic int next_idx(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/alu_req_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  // Scan NUM_REQ slots starting at ptr; the first valid one wins.
  always_comb begin
    logic found;
    int   j;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (en && !found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Time-shares one combinational ALU between NUM_REQ requesters.
// A granted request is registered onto the ALU inputs, the result is captured
// one cycle later and returned on a valid/ready channel tagged with its ID.
module alu_req_scheduler
  import alu_req_scheduler_pkg::*;
#(
  parameter  int NUM_REQ      = 2,
  parameter  int DATA_WIDTH   = DATA_WIDTH_D,
  parameter  int OPCODE_WIDTH = OPCODE_WIDTH_D,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_A,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_B,
  input  logic [NUM_REQ-1:0][OPCODE_WIDTH-1:0]   req_opcode,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [ID_W-1:0]                        rsp_id,
  output logic [DATA_WIDTH-1:0]                  rsp_result,
  output logic [FLAGS_W-1:0]                     rsp_flags,
  output logic [DATA_WIDTH-1:0]                  alu_A,
  output logic [DATA_WIDTH-1:0]                  alu_B,
  output logic [OPCODE_WIDTH-1:0]                alu_opcode,
  input  logic [DATA_WIDTH-1:0]                  alu_result,
  input  logic [FLAGS_W-1:0]                     alu_flags,
  output logic [15:0]                            op_count
);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     gidx;
  logic                accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (state == IDLE),
    .grant     (grant),
    .grant_idx (gidx)
  );

  // Grant is already gated by IDLE and by req_valid, so any grant bit is an accept.
  assign req_ready = grant;
  assign accept    = |grant;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: IDLE -> EXEC on accept, EXEC -> RESP always, RESP -> IDLE on handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = EXEC;
      EXEC:                   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath: latch winner operands, capture ALU output, retire response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_opcode <= '0;
      rsp_id     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          alu_A      <= req_A[gidx];
          alu_B      <= req_B[gidx];
          alu_opcode <= req_opcode[gidx];
          rsp_id     <= gidx;
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_flags  <= {alu_flags[FLAG_C], alu_flags[FLAG_Z],
                         alu_flags[FLAG_P], alu_flags[FLAG_V]};
          rsp_valid  <= 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          op_count  <= op_count + 16'd1;
          // Pointer moves past the requester just served.
          ptr       <= ID_W'(next_idx(int'(rsp_id), NUM_REQ));
        end
        default: ;
      endcase
    end
  end

endmodule
